// File: rtl/ps2_pad_key_decoder_if.sv
// Byte stream from the PS/2 receiver into the decoder, and the key-held
// flags plus start pulse going out to the pad controllers.
interface ps2_pad_key_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       left_up;
  logic       left_down;
  logic       right_up;
  logic       right_down;
  logic       start_pulse;

  modport master (
    output rx_data, rx_valid,
    input  left_up, left_down, right_up, right_down, start_pulse
  );

  modport slave (
    input  rx_data, rx_valid,
    output left_up, left_down, right_up, right_down, start_pulse
  );
endinterface

// File: rtl/ps2_pad_key_decoder.sv
// PS/2 scan-code-set-2 byte decoder for the paddle keys.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | no prefix pending; next code byte is a base make
// EXT     | E0 seen; next code byte is an extended make
// BRK     | F0 seen; next code byte is a base break
// EXT_BRK | E0 F0 seen; next code byte is an extended break
//
// Prefix states expire back to IDLE after TIMEOUT_CYCLES quiet cycles so a
// lost byte cannot leave the decoder stuck with a stale prefix.
module ps2_pad_key_decoder #(
  parameter int TIMEOUT_CYCLES = 130_000
) (
  input logic                 clk,
  input logic                 rst,
  ps2_pad_key_decoder_if.slave bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] B_EXT   = 8'hE0;
  localparam logic [7:0] B_BRK   = 8'hF0;
  localparam logic [7:0] B_W     = 8'h1D;
  localparam logic [7:0] B_S     = 8'h1B;
  localparam logic [7:0] B_SPACE = 8'h29;
  localparam logic [7:0] B_UP    = 8'h75;
  localparam logic [7:0] B_DOWN  = 8'h72;
  localparam logic [7:0] B_BAT   = 8'hAA;
  localparam logic [7:0] B_ERR   = 8'hFC;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             lu, ld, ru, rd, sp;
  logic             lu_nx, ld_nx, ru_nx, rd_nx, sp_nx;

  // State, timeout counter and all output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      lu    <= 1'b0;
      ld    <= 1'b0;
      ru    <= 1'b0;
      rd    <= 1'b0;
      sp    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      lu    <= lu_nx;
      ld    <= ld_nx;
      ru    <= ru_nx;
      rd    <= rd_nx;
      sp    <= sp_nx;
    end
  end

  // Next state, prefix timeout, and flag updates from the incoming byte.
  // A byte arriving in the expiry cycle wins over the timeout.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lu_nx    = lu;
    ld_nx    = ld;
    ru_nx    = ru;
    rd_nx    = rd;
    sp_nx    = 1'b0;

    if (bus.rx_valid) begin
      cnt_nx = '0;
      if (bus.rx_data == B_EXT) begin
        state_nx = EXT;
      end else if (bus.rx_data == B_BRK) begin
        state_nx = (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
      end else begin
        state_nx = IDLE;
        unique case (state)
          IDLE: begin
            case (bus.rx_data)
              B_W:     lu_nx = 1'b1;
              B_S:     ld_nx = 1'b1;
              B_SPACE: sp_nx = 1'b1;
              B_BAT, B_ERR: begin
                lu_nx = 1'b0;
                ld_nx = 1'b0;
                ru_nx = 1'b0;
                rd_nx = 1'b0;
              end
              default: ;
            endcase
          end
          EXT: begin
            case (bus.rx_data)
              B_UP:    ru_nx = 1'b1;
              B_DOWN:  rd_nx = 1'b1;
              default: ;
            endcase
          end
          BRK: begin
            case (bus.rx_data)
              B_W:     lu_nx = 1'b0;
              B_S:     ld_nx = 1'b0;
              default: ;
            endcase
          end
          EXT_BRK: begin
            case (bus.rx_data)
              B_UP:    ru_nx = 1'b0;
              B_DOWN:  rd_nx = 1'b0;
              default: ;
            endcase
          end
        endcase
      end
    end else if (state != IDLE) begin
      if (cnt == CNT_LAST) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
  end

  assign bus.left_up     = lu;
  assign bus.left_down   = ld;
  assign bus.right_up    = ru;
  assign bus.right_down  = rd;
  assign bus.start_pulse = sp;

endmodule

// File: tb/tb_ps2_pad_key_decoder.sv
module tb_ps2_pad_key_decoder;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   run = 1'b0;

  ps2_pad_key_decoder_if bus ();

  ps2_pad_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: keys held as a set of booleans, pending prefix as two
  // "seen" flags with an age in quiet cycles.
  bit m_lu, m_ld, m_ru, m_rd, m_sp;
  bit pend_ext, pend_brk;
  int age;

  always @(posedge clk) begin
    m_sp = 1'b0;
    if (rst) begin
      {m_lu, m_ld, m_ru, m_rd} = '0;
      pend_ext = 1'b0;
      pend_brk = 1'b0;
      age = 0;
    end else if (bus.rx_valid) begin
      age = 0;
      if (bus.rx_data == 8'hE0) begin
        pend_ext = 1'b1;
        pend_brk = 1'b0;
      end else if (bus.rx_data == 8'hF0) begin
        pend_brk = 1'b1;
      end else begin
        if (!pend_ext) begin
          if (bus.rx_data == 8'h1D) m_lu = !pend_brk;
          if (bus.rx_data == 8'h1B) m_ld = !pend_brk;
          if (bus.rx_data == 8'h29 && !pend_brk) m_sp = 1'b1;
          if (!pend_brk && (bus.rx_data == 8'hAA || bus.rx_data == 8'hFC))
            {m_lu, m_ld, m_ru, m_rd} = '0;
        end else begin
          if (bus.rx_data == 8'h75) m_ru = !pend_brk;
          if (bus.rx_data == 8'h72) m_rd = !pend_brk;
        end
        pend_ext = 1'b0;
        pend_brk = 1'b0;
      end
    end else if (pend_ext || pend_brk) begin
      age++;
      if (age == T) begin
        pend_ext = 1'b0;
        pend_brk = 1'b0;
        age = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (run) begin
      checks++;
      if ({bus.left_up, bus.left_down, bus.right_up, bus.right_down, bus.start_pulse}
          !== {m_lu, m_ld, m_ru, m_rd, m_sp}) begin
        failures++;
        $display("FAIL model_cmp t=%0t got lu/ld/ru/rd/sp=%b%b%b%b%b want %b%b%b%b%b", $time,
                 bus.left_up, bus.left_down, bus.right_up, bus.right_down, bus.start_pulse,
                 m_lu, m_ld, m_ru, m_rd, m_sp);
      end
    end
  end

  // Drives a byte for exactly one cycle; consecutive calls are back-to-back.
  task automatic put(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic [4:0] want);
    logic [4:0] got;
    got = {bus.left_up, bus.left_down, bus.right_up, bus.right_down, bus.start_pulse};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got lu/ld/ru/rd/sp=%b want %b", name, got, want);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b1;
    gap(3);
    rst = 1'b0;
    run = 1'b1;
    expect_out("reset", 5'b00000);

    // W make then break
    put(8'h1D);           expect_out("w_make", 5'b10000);
    gap(2);
    put(8'hF0); put(8'h1D); expect_out("w_break", 5'b00000);
    gap(2);

    // arrow up make then break
    put(8'hE0); put(8'h75); expect_out("up_make", 5'b00100);
    gap(1);
    put(8'hE0); gap(1); put(8'hF0); gap(1); put(8'h75);
    expect_out("up_break", 5'b00000);
    gap(2);

    // S and arrow down held together, typematic S, then S break
    put(8'h1B); gap(1); put(8'hE0); put(8'h72);
    expect_out("both_down", 5'b01010);
    for (int i = 0; i < 5; i++) begin
      gap(3); put(8'h1B);
    end
    expect_out("typematic", 5'b01010);
    put(8'hF0); put(8'h1B); expect_out("s_break", 5'b00010);
    put(8'hE0); put(8'hF0); put(8'h72); expect_out("down_break", 5'b00000);
    gap(2);

    // SPACE pulses
    put(8'h29); expect_out("space1", 5'b00001);
    gap(1);     expect_out("space1_end", 5'b00000);
    gap(2);
    put(8'h29); expect_out("space2", 5'b00001);
    put(8'hF0); expect_out("space2_end", 5'b00000);
    put(8'h29); expect_out("space_brk", 5'b00000);
    put(8'hE0); put(8'h29); expect_out("ext_space", 5'b00000);
    gap(2);

    // prefix timeout: byte one cycle after expiry is base (unknown)
    put(8'hE0); gap(T); put(8'h75); expect_out("timeout_late", 5'b00000);
    gap(2);
    // byte in the expiry cycle still decodes as extended
    put(8'hE0); gap(T - 1); put(8'h75); expect_out("timeout_edge", 5'b00100);
    put(8'hE0); put(8'hF0); put(8'h75); expect_out("timeout_clr", 5'b00000);
    gap(2);
    // F0 timeout: break of W lost, W remains held
    put(8'h1D); put(8'hF0); gap(T); put(8'h1D); expect_out("brk_timeout", 5'b10000);
    gap(2);

    // AA in BRK does not clear, AA in IDLE clears
    put(8'h1B); put(8'hE0); put(8'h75);
    put(8'hF0); put(8'hAA); expect_out("aa_in_brk", 5'b11100);
    gap(1); put(8'hAA); expect_out("aa_clear", 5'b00000);
    put(8'h1D); put(8'hFC); expect_out("fc_clear", 5'b00000);
    gap(2);

    // reset mid-sequence, trailing byte decoded as base
    put(8'h1D); put(8'hE0);
    rst = 1'b1; gap(1); rst = 1'b0;
    expect_out("mid_reset", 5'b00000);
    put(8'h1D); expect_out("after_reset", 5'b10000);
    gap(3);

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
